// File: rtl/data_bus_lane_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_bus_lane_loader: scatters a valid/ready beat stream into masked lanes |
// | of the data-bus combiner. Optional DATA_BUS_LOADER_TIMEOUT_EN. Rev 1.0     |
// +----------------------------------------------------------------------------+
module data_bus_lane_loader #(
  parameter int UNIT_NUM    = 5,
  parameter int UNIT_WIDTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                           sys_clk,
  input  logic                           rstn,
  input  logic                           start_i,
  input  logic [UNIT_NUM-1:0]            lane_mask_i,
  input  logic [UNIT_WIDTH-1:0]          din_i,
  input  logic                           din_valid_i,
  output logic                           din_ready_o,
  output logic [UNIT_NUM*UNIT_WIDTH-1:0] port_in_o,
  output logic [UNIT_NUM-1:0]            load_en_o,
  output logic [UNIT_NUM-1:0]            lane_rstn_o,
  output logic                           busy_o,
  output logic                           frame_done_o,
  output logic                           timeout_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [UNIT_NUM-1:0] ONE_LSB = {{(UNIT_NUM-1){1'b0}}, 1'b1};

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cfg
    $error("TIMEOUT_CYC must be at least 1");
  end

  logic [2:0]            state_q, state_d;
  logic [UNIT_NUM-1:0]   rem_q, rem_d;
  logic [UNIT_NUM-1:0]   load_en_q, load_en_d;
  logic [UNIT_NUM-1:0]   lane_rstn_q, lane_rstn_d;
  logic [UNIT_WIDTH-1:0] din_q, din_d;
  logic                  busy_q, done_q, timeout_q, timeout_d;
  logic                  accept, last_beat, idle_expired;
  logic [UNIT_NUM-1:0]   low_bit;

  assign din_ready_o = (state_q == S_FILL);
  assign accept      = din_ready_o & din_valid_i;
  // Two's-complement trick isolates the lowest pending lane.
  assign low_bit     = rem_q & (~rem_q + ONE_LSB);
  assign last_beat   = (rem_q == low_bit);

`ifdef DATA_BUS_LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = '0;
    if (state_q == S_FILL && !accept) idle_cnt_d = idle_cnt_q + CNT_W'(1);
  end

  assign idle_expired = (state_q == S_FILL) && !accept &&
                        (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk) begin
    if (!rstn) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`else
  assign idle_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    din_d     = din_q;
    load_en_d = '0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rem_d   = lane_mask_i;
          state_d = (lane_mask_i != '0) ? S_CLEAR : S_DONE;
        end
      end
      S_CLEAR: state_d = S_FILL;
      S_FILL: begin
        if (accept) begin
          din_d     = din_i;
          load_en_d = low_bit;
          rem_d     = rem_q & ~low_bit;
          if (last_beat) state_d = S_FLUSH;
        end else if (idle_expired) begin
          state_d   = S_IDLE;
          rem_d     = '0;
          timeout_d = 1'b1;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        rem_d   = '0;
      end
    endcase
    // Only the lanes of the new frame are cleared; the rest keep their data.
    lane_rstn_d = (state_d == S_CLEAR) ? ~rem_d : '1;
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      din_q       <= '0;
      load_en_q   <= '0;
      lane_rstn_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      din_q       <= din_d;
      load_en_q   <= load_en_d;
      lane_rstn_q <= lane_rstn_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      timeout_q   <= timeout_d;
    end
  end

  assign port_in_o    = {UNIT_NUM{din_q}};
  assign load_en_o    = load_en_q;
  assign lane_rstn_o  = lane_rstn_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign timeout_o    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_lane_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_bus_lane_loader: frame-level scoreboard bench for the lane loader. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_data_bus_lane_loader;

  localparam int UN = 5;
  localparam int UW = 4;

  logic              sys_clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start_i = 1'b0;
  logic [UN-1:0]     lane_mask_i = '0;
  logic [UW-1:0]     din_i = '0;
  logic              din_valid_i = 1'b0;
  logic              din_ready_o;
  logic [UN*UW-1:0]  port_in_o;
  logic [UN-1:0]     load_en_o;
  logic [UN-1:0]     lane_rstn_o;
  logic              busy_o, frame_done_o, timeout_o;

  int checks = 0;
  int errors = 0;

  data_bus_lane_loader #(.UNIT_NUM(UN), .UNIT_WIDTH(UW), .TIMEOUT_CYC(16)) dut (
    .sys_clk(sys_clk), .rstn(rstn), .start_i(start_i), .lane_mask_i(lane_mask_i),
    .din_i(din_i), .din_valid_i(din_valid_i), .din_ready_o(din_ready_o),
    .port_in_o(port_in_o), .load_en_o(load_en_o), .lane_rstn_o(lane_rstn_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .timeout_o(timeout_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic test_reset();
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({busy_o, frame_done_o, timeout_o, din_ready_o, load_en_o, lane_rstn_o, port_in_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b to=%b rdy=%b ld=%b rstn=%b port=%h want all 0",
               busy_o, frame_done_o, timeout_o, din_ready_o, load_en_o, lane_rstn_o, port_in_o);
    end
    rstn = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (lane_rstn_o !== '1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: lane_rstn=%b busy=%b want 11111 0", lane_rstn_o, busy_o);
    end
  endtask

  // gap_mode: 0 always valid, 1 random valid, 2 three-cycle gap after first beat,
  // 3 forty-cycle gap after second beat.
  task automatic run_frame(input logic [UN-1:0] mask, input int gap_mode, input bit poke);
    int lanes[$];
    logic [UN-1:0] exp_load;
    logic [UW-1:0] exp_data;
    int idx, cyc;
    bit v;
    for (int i = 0; i < UN; i++) if (mask[i]) lanes.push_back(i);
    @(negedge sys_clk);
    checks++;
    if (busy_o !== 1'b0 || din_ready_o !== 1'b0 || lane_rstn_o !== '1) begin
      errors++;
      $display("FAIL idle_before_frame: busy=%b rdy=%b lane_rstn=%b want 0 0 11111",
               busy_o, din_ready_o, lane_rstn_o);
    end
    start_i = 1'b1; lane_mask_i = mask; din_valid_i = 1'b0;
    @(negedge sys_clk);
    start_i = 1'b0; lane_mask_i = UN'($urandom);
    if (lanes.size() == 0) begin
      checks++;
      if ({busy_o, frame_done_o, din_ready_o, load_en_o} !== {3'b110, {UN{1'b0}}}) begin
        errors++;
        $display("FAIL empty_mask_done: busy=%b done=%b rdy=%b ld=%b want 1 1 0 00000",
                 busy_o, frame_done_o, din_ready_o, load_en_o);
      end
      @(negedge sys_clk);
      checks++;
      if ({busy_o, frame_done_o} !== 2'b00) begin
        errors++;
        $display("FAIL empty_mask_end: busy=%b done=%b want 0 0", busy_o, frame_done_o);
      end
      return;
    end
    checks++;
    if (lane_rstn_o !== ~mask || busy_o !== 1'b1 || din_ready_o !== 1'b0 || load_en_o !== '0) begin
      errors++;
      $display("FAIL clear_cycle: lane_rstn=%b busy=%b rdy=%b ld=%b want %b 1 0 00000",
               lane_rstn_o, busy_o, din_ready_o, load_en_o, ~mask);
    end
    exp_load = '0; exp_data = '0; idx = 0; cyc = 0;
    forever begin
      @(negedge sys_clk);
      checks++;
      if (load_en_o !== exp_load || (exp_load != '0 && port_in_o !== {UN{exp_data}})) begin
        errors++;
        $display("FAIL lane_load: ld=%b port=%h want ld=%b port=%h",
                 load_en_o, port_in_o, exp_load, {UN{exp_data}});
      end
      checks++;
      if (din_ready_o !== (idx < lanes.size()) || busy_o !== 1'b1 || frame_done_o !== 1'b0 ||
          timeout_o !== 1'b0 || lane_rstn_o !== '1) begin
        errors++;
        $display("FAIL fill_status: rdy=%b busy=%b done=%b to=%b lane_rstn=%b want %b 1 0 0 11111",
                 din_ready_o, busy_o, frame_done_o, timeout_o, lane_rstn_o, idx < lanes.size());
      end
      if (idx == lanes.size()) break;
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        2:       v = !(cyc >= 1 && cyc <= 3);
        default: v = !(cyc >= 2 && cyc < 42);
      endcase
      din_valid_i = v; din_i = UW'($urandom);
      if (poke) begin start_i = 1'($urandom); lane_mask_i = UN'($urandom); end
      exp_load = '0;
      if (v) begin exp_load[lanes[idx]] = 1'b1; exp_data = din_i; idx++; end
      cyc++;
      if (cyc > 300) begin
        checks++; errors++;
        $display("FAIL frame_bound: frame did not complete in 300 cycles");
        din_valid_i = 1'b0; start_i = 1'b0;
        return;
      end
    end
    // Valid stays high through FLUSH so a spurious extra accept would show up.
    start_i = 1'b0; din_valid_i = 1'b1; din_i = UW'($urandom);
    @(negedge sys_clk);
    din_valid_i = 1'b0;
    checks++;
    if ({frame_done_o, busy_o, din_ready_o, load_en_o} !== {3'b110, {UN{1'b0}}}) begin
      errors++;
      $display("FAIL frame_done: done=%b busy=%b rdy=%b ld=%b want 1 1 0 00000",
               frame_done_o, busy_o, din_ready_o, load_en_o);
    end
    @(negedge sys_clk);
    checks++;
    if ({frame_done_o, busy_o, load_en_o} !== {2'b00, {UN{1'b0}}}) begin
      errors++;
      $display("FAIL frame_end: done=%b busy=%b ld=%b want 0 0 00000", frame_done_o, busy_o, load_en_o);
    end
  endtask

  task automatic test_reset_mid_fill();
    @(negedge sys_clk); start_i = 1'b1; lane_mask_i = 5'b11111;
    @(negedge sys_clk); start_i = 1'b0;
    @(negedge sys_clk); din_valid_i = 1'b1; din_i = 4'h9;
    repeat (2) @(negedge sys_clk);
    din_valid_i = 1'b0; rstn = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({busy_o, frame_done_o, timeout_o, din_ready_o, load_en_o, lane_rstn_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_fill: busy=%b done=%b to=%b rdy=%b ld=%b lane_rstn=%b want all 0",
               busy_o, frame_done_o, timeout_o, din_ready_o, load_en_o, lane_rstn_o);
    end
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      checks++;
      if ({busy_o, frame_done_o, timeout_o, load_en_o} !== '0 || lane_rstn_o !== '1) begin
        errors++;
        $display("FAIL after_reset_quiet: busy=%b done=%b to=%b ld=%b lane_rstn=%b want 0 0 0 00000 11111",
                 busy_o, frame_done_o, timeout_o, load_en_o, lane_rstn_o);
      end
    end
  endtask

`ifdef DATA_BUS_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    seen = -1;
    @(negedge sys_clk); start_i = 1'b1; lane_mask_i = 5'b11111;
    @(negedge sys_clk); start_i = 1'b0;
    @(negedge sys_clk); din_valid_i = 1'b1; din_i = 4'h3;
    repeat (2) @(negedge sys_clk);
    din_valid_i = 1'b0;
    for (int t = 1; t <= 40 && seen < 0; t++) begin
      @(negedge sys_clk);
      if (timeout_o === 1'b1) seen = t;
    end
    checks++;
    if (seen != 16) begin
      errors++;
      $display("FAIL timeout_latency: pulse after %0d cycles want 16", seen);
    end
    checks++;
    if (busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: busy=%b done=%b want 0 0", busy_o, frame_done_o);
    end
    @(negedge sys_clk);
    checks++;
    if (timeout_o !== 1'b0 || frame_done_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_width: to=%b done=%b want 0 0", timeout_o, frame_done_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    run_frame(5'b11111, 0, 1'b0);
    run_frame(5'b10100, 0, 1'b0);
    run_frame(5'b00000, 0, 1'b0);
    run_frame(5'b01101, 2, 1'b1);
    test_reset_mid_fill();
    run_frame(5'b10001, 0, 1'b0);
`ifdef DATA_BUS_LOADER_TIMEOUT_EN
    test_timeout();
`else
    run_frame(5'b11111, 3, 1'b0);
`endif
    for (int n = 0; n < 25; n++) begin
      logic [UN-1:0] m;
      m = UN'($urandom);
      run_frame(m, 1, 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
